// File: rtl/merger_lane_scheduler_pkg.sv
// Shared constants and FSM encoding for the merge-tree lane scheduler.
// Also carries the saturating increment used by the optional performance counters.
package merger_defines;

    localparam int RADIX      = 4;
    localparam int COORD_BITS = 8;

    // All-ones is never a real coordinate: it marks a lane whose fiber has ended.
    localparam logic [COORD_BITS-1:0] SENTINEL = {COORD_BITS{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MERGE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
        return (en && (value != 32'hFFFF_FFFF)) ? value + 32'd1 : value;
    endfunction

endpackage

// File: rtl/merger_sched_outreg.sv
// One-entry valid/ready output register carrying the merged coordinate and its last flag.
// Accepts a new beat whenever it is empty or its current beat is leaving this cycle.
module merger_sched_outreg
    import merger_defines::*;
#(
    parameter int W = COORD_BITS
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_coord_i,
    input  logic         in_last_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    output logic [W-1:0] out_coord_o,
    output logic         out_last_o,
    input  logic         out_ready_i
);

    logic         valid_q;
    logic [W-1:0] coord_q;
    logic         last_q;

    assign in_ready_o = !valid_q || out_ready_i;

    always_ff @(posedge clock) begin
        // NOTE: the payload is reset too, so every output reads 0 after reset rather than X.
        if (!reset) begin
            valid_q <= 1'b0;
            coord_q <= '0;
            last_q  <= 1'b0;
        end else if (in_valid_i && in_ready_o) begin
            valid_q <= 1'b1;
            coord_q <= in_coord_i;
            last_q  <= in_last_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    assign out_valid_o = valid_q;
    assign out_coord_o = coord_q;
    assign out_last_o  = last_q;

endmodule

// File: rtl/merger_lane_scheduler.sv
// Feeds RADIX coordinate fibers through an external merger and registers the merged stream.
// Optional macro MERGER_SCHED_PERF_COUNTERS_EN adds beat and stall counters.
module merger_lane_scheduler
    import merger_defines::*;
#(
    parameter int MERGER_RADIX      = RADIX,
    parameter int MERGER_COORD_BITS = COORD_BITS
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [MERGER_RADIX-1:0]               lane_enable,
    input  logic [MERGER_RADIX-1:0]               lane_valid,
    input  logic [MERGER_RADIX-1:0]               lane_last,
    input  logic [MERGER_RADIX*MERGER_COORD_BITS-1:0] lane_coord,
    output logic [MERGER_RADIX-1:0]               lane_pop,
    output logic [MERGER_RADIX*MERGER_COORD_BITS-1:0] m_coord_in,
    output logic                                  m_selected,
    input  logic [MERGER_RADIX-1:0]               m_fetch_next,
    input  logic [MERGER_COORD_BITS-1:0]          m_coord,
    output logic                                  out_valid,
    output logic [MERGER_COORD_BITS-1:0]          out_coord,
    output logic                                  out_last,
    input  logic                                  out_ready,
    output logic                                  busy,
    output logic                                  done
`ifdef MERGER_SCHED_PERF_COUNTERS_EN
    ,
    output logic [31:0]                           perf_out_beats,
    output logic [31:0]                           perf_input_stalls,
    output logic [31:0]                           perf_output_stalls
`endif
);

    localparam int R = MERGER_RADIX;
    localparam int C = MERGER_COORD_BITS;
    localparam logic [C-1:0] LANE_SENTINEL = {C{1'b1}};

    sched_state_e state_q;
    logic [R-1:0] live_q;
    logic         heads_ok;
    logic         stage_ready;
    logic         fire;
    logic         last_fire;
    logic         beat_taken;
    logic [R-1:0] live_rem;

    always_comb begin
        // NOTE: default first so no path through the loop can leave a bit unassigned (no latch).
        m_coord_in = '1;
        for (int i = 0; i < R; i++) begin
            m_coord_in[i*C +: C] = live_q[i] ? lane_coord[i*C +: C] : LANE_SENTINEL;
        end
    end

    // Reset is folded into fire so a mid-job reset cycle neither pops nor captures a beat.
    assign heads_ok   = &(lane_valid | ~live_q);
    assign fire       = reset && (state_q == ST_MERGE) && heads_ok && stage_ready;
    assign m_selected = fire;
    assign lane_pop   = fire ? (m_fetch_next & live_q) : '0;
    assign live_rem   = live_q & ~(lane_pop & lane_last);
    assign last_fire  = fire && (live_rem == '0);
    assign beat_taken = out_valid && out_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            live_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        live_q  <= lane_enable;
                        state_q <= (lane_enable == '0) ? ST_DONE : ST_MERGE;
                    end
                end
                ST_MERGE: begin
                    if (fire) begin
                        live_q <= live_rem;
                        if (last_fire) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (beat_taken && out_last) begin
                        state_q <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

    merger_sched_outreg #(.W(C)) u_outreg (
        .clock       (clock),
        .reset       (reset),
        .in_valid_i  (fire),
        .in_coord_i  (m_coord),
        .in_last_i   (last_fire),
        .in_ready_o  (stage_ready),
        .out_valid_o (out_valid),
        .out_coord_o (out_coord),
        .out_last_o  (out_last),
        .out_ready_i (out_ready)
    );

`ifdef MERGER_SCHED_PERF_COUNTERS_EN
    logic [31:0] beats_q;
    logic [31:0] in_stalls_q;
    logic [31:0] out_stalls_q;

    always_ff @(posedge clock) begin
        if (!reset || (state_q == ST_IDLE && start)) begin
            beats_q      <= '0;
            in_stalls_q  <= '0;
            out_stalls_q <= '0;
        end else begin
            beats_q      <= sat_inc(beats_q, beat_taken);
            in_stalls_q  <= sat_inc(in_stalls_q, (state_q == ST_MERGE) && !heads_ok);
            out_stalls_q <= sat_inc(out_stalls_q, (state_q == ST_MERGE) && out_valid && !out_ready);
        end
    end

    assign perf_out_beats     = beats_q;
    assign perf_input_stalls  = in_stalls_q;
    assign perf_output_stalls = out_stalls_q;
`endif

endmodule

// File: tb/tb_merger_lane_scheduler.sv
// Self-checking bench: lane FIFO and merger models, a job table and multi-cycle corner sequences.
module tb_merger_lane_scheduler;
    import merger_defines::*;

    localparam int R = RADIX;
    localparam int C = COORD_BITS;

    typedef struct packed {
        logic [R-1:0]              en;
        logic [R-1:0]              inject;
        logic [R-1:0][2:0][C-1:0]  fib;
        logic [R-1:0][1:0]         len;
        logic [7:0]                exp_beats;
        logic [7:0]                exp_pops;
        logic [R-1:0]              exp_first_pop;
    } vec_t;

    typedef struct packed {
        logic [C-1:0] coord;
        logic         last;
    } exp_t;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [R-1:0]   lane_enable = '0;
    logic [R-1:0]   lane_valid, lane_last, lane_pop, m_fetch_next;
    logic [R*C-1:0] lane_coord, m_coord_in;
    logic           m_selected, out_valid, out_last, busy, done;
    logic           out_ready = 1'b1;
    logic [C-1:0]   m_coord, out_coord;
`ifdef MERGER_SCHED_PERF_COUNTERS_EN
    logic [31:0]    perf_out_beats, perf_input_stalls, perf_output_stalls;
`endif

    merger_lane_scheduler dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .lane_enable  (lane_enable),
        .lane_valid   (lane_valid),
        .lane_last    (lane_last),
        .lane_coord   (lane_coord),
        .lane_pop     (lane_pop),
        .m_coord_in   (m_coord_in),
        .m_selected   (m_selected),
        .m_fetch_next (m_fetch_next),
        .m_coord      (m_coord),
        .out_valid    (out_valid),
        .out_coord    (out_coord),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done)
`ifdef MERGER_SCHED_PERF_COUNTERS_EN
        ,
        .perf_out_beats     (perf_out_beats),
        .perf_input_stalls  (perf_input_stalls),
        .perf_output_stalls (perf_output_stalls)
`endif
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Lane FIFO model: fixed fiber storage and per-lane read pointers.
    logic [C-1:0] fib_m [R][3];
    int           len_m [R];
    logic [R-1:0] stall_m  = '0;
    logic [R-1:0] inject_m = '0;
    int           load_gen = 0;
    int           seen_gen = 0;
    int           rd_ptr [R];
    logic [R-1:0] pop_snap;

    always_comb begin
        lane_valid = '0;
        lane_last  = '0;
        lane_coord = '0;
        for (int i = 0; i < R; i++) begin
            if (rd_ptr[i] < len_m[i]) begin
                lane_valid[i]        = !stall_m[i];
                lane_coord[i*C +: C] = fib_m[i][rd_ptr[i]];
                lane_last[i]         = (rd_ptr[i] == len_m[i] - 1);
            end
        end
    end

    always @(posedge clock) begin
        pop_snap = lane_pop;
        #1;
        if (seen_gen != load_gen) begin
            for (int i = 0; i < R; i++) rd_ptr[i] = 0;
            seen_gen = load_gen;
        end else begin
            for (int i = 0; i < R; i++)
                if (pop_snap[i] && rd_ptr[i] < len_m[i]) rd_ptr[i] = rd_ptr[i] + 1;
        end
    end

    // Merger model: smallest head wins, every tying lane is fetched; inject_m adds stray bits.
    always_comb begin
        m_coord = '1;
        for (int i = 0; i < R; i++)
            if (m_coord_in[i*C +: C] < m_coord) m_coord = m_coord_in[i*C +: C];
        m_fetch_next = inject_m;
        for (int i = 0; i < R; i++)
            if (m_coord_in[i*C +: C] == m_coord) m_fetch_next[i] = 1'b1;
    end

    // Scoreboard and per-job monitor.
    exp_t         exp_q [$];
    exp_t         mon_e;
    int           cyc = 0;
    logic [R-1:0] job_en = '0;
    logic [R-1:0] first_pop = '0;
    int           pop_total = 0, bad_pop = 0, hs_count = 0, gap_cnt = 0;
    int           done_count = 0, done_cyc = 0, last_hs = 0;
    bit           hs_seen = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            if (start && !busy) begin
                job_en = lane_enable; first_pop = '0; pop_total = 0; bad_pop = 0;
                hs_count = 0; gap_cnt = 0; done_count = 0; hs_seen = 1'b0;
            end
            if (lane_pop != '0) begin
                pop_total += $countones(lane_pop);
                if (first_pop == '0) first_pop = lane_pop;
                if ((lane_pop & ~job_en) != '0) bad_pop++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 64'(out_coord), 64'(SENTINEL));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat_coord", 64'(out_coord), 64'(mon_e.coord));
                    check("beat_last", 64'(out_last), 64'(mon_e.last));
                end
                if (hs_seen && cyc != last_hs + 1) gap_cnt++;
                hs_seen = 1'b1;
                last_hs = cyc;
                hs_count++;
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
            for (int i = 0; i < R; i++)
                assert (!(busy && lane_valid[i] && lane_coord[i*C +: C] == SENTINEL &&
                          m_coord_in[i*C +: C] == SENTINEL))
                else $error("live lane %0d presents the sentinel coordinate", i);
        end
        cyc++;
    end

    function automatic vec_t mk(input logic [R-1:0] en, input logic [R-1:0] inj,
                                input logic [R*3*C-1:0] data, input logic [2*R-1:0] lens,
                                input logic [7:0] beats, input logic [7:0] pops,
                                input logic [R-1:0] fp);
        vec_t v;
        v.en = en; v.inject = inj; v.fib = data; v.len = lens;
        v.exp_beats = beats; v.exp_pops = pops; v.exp_first_pop = fp;
        return v;
    endfunction

    task automatic load(input vec_t v);
        int   vals [$];
        exp_t it;
        inject_m = v.inject;
        stall_m  = '0;
        for (int i = 0; i < R; i++) begin
            len_m[i] = v.en[i] ? int'(v.len[i]) : 0;
            for (int k = 0; k < 3; k++) fib_m[i][k] = v.fib[i][k];
            for (int k = 0; k < len_m[i]; k++) vals.push_back(int'(v.fib[i][k]));
        end
        load_gen++;
        vals.sort();
        for (int j = 0; j < vals.size(); j++) begin
            if (j == 0 || vals[j] != vals[j-1]) begin
                it.coord = C'(vals[j]);
                it.last  = 1'b0;
                exp_q.push_back(it);
            end
        end
        if (exp_q.size() > 0) begin
            it = exp_q.pop_back();
            it.last = 1'b1;
            exp_q.push_back(it);
        end
    endtask

    task automatic launch(input vec_t v);
        @(negedge clock);
        load(v);
        lane_enable = v.en;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic finish_job(input vec_t v, input int exp_gaps);
        for (int n = 0; n < 400 && done_count == 0; n++) @(negedge clock);
        repeat (3) @(negedge clock);
        check("done_pulses", 64'(done_count), 1);
        check("busy_idle", 64'(busy), 0);
        check("beats", 64'(hs_count), 64'(v.exp_beats));
        check("pops", 64'(pop_total), 64'(v.exp_pops));
        check("first_pop", 64'(first_pop), 64'(v.exp_first_pop));
        check("masked_pops", 64'(bad_pop), 0);
        check("gaps", 64'(gap_cnt), 64'(exp_gaps));
        check("sb_left", 64'(exp_q.size()), 0);
        if (v.exp_beats != 0) check("done_latency", 64'(done_cyc), 64'(last_hs + 1));
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = mk(4'b0001, 4'b1000, {72'd0, 8'd9, 8'd5, 8'd1},
                     {2'd0, 2'd0, 2'd0, 2'd3}, 8'd3, 8'd3, 4'b0001);
        vecs[1] = mk(4'b1111, 4'b0000,
                     {8'd0, 8'd9, 8'd5, 8'd0, 8'd8, 8'd4, 8'd0, 8'd6, 8'd2, 8'd0, 8'd7, 8'd3},
                     {2'd2, 2'd2, 2'd2, 2'd2}, 8'd8, 8'd8, 4'b0010);
        vecs[2] = mk(4'b0101, 4'b0000, {24'd0, 16'd0, 8'd4, 24'd0, 16'd0, 8'd4},
                     {2'd0, 2'd1, 2'd0, 2'd1}, 8'd1, 8'd2, 4'b0101);
        vecs[3] = mk(4'b0000, 4'b0000, 96'd0, 8'd0, 8'd0, 8'd0, 4'b0000);
        vecs[4] = mk(4'b1011, 4'b0000,
                     {8'd8, 8'd6, 8'd2, 24'd0, 8'd0, 8'd7, 8'd3, 8'd6, 8'd3, 8'd1},
                     {2'd3, 2'd0, 2'd2, 2'd3}, 8'd6, 8'd8, 4'b0001);
        vecs[5] = mk(4'b1111, 4'b0000,
                     {8'd24, 8'd14, 8'd4, 8'd23, 8'd13, 8'd3, 8'd22, 8'd12, 8'd2, 8'd21, 8'd11, 8'd1},
                     {2'd3, 2'd3, 2'd3, 2'd3}, 8'd12, 8'd12, 4'b0001);
        for (int i = 0; i < R; i++) begin
            len_m[i] = 0;
            rd_ptr[i] = 0;
        end

        repeat (3) @(negedge clock);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_out_coord", 64'(out_coord), 0);
        check("rst_out_last", 64'(out_last), 0);
        check("rst_lane_pop", 64'(lane_pop), 0);
        check("rst_selected", 64'(m_selected), 0);
        check("rst_coord_in", 64'(m_coord_in), 64'({R{SENTINEL}}));
        reset = 1'b1;

        for (int r = 0; r < 5; r++) begin
            launch(vecs[r]);
            finish_job(vecs[r], 0);
        end

        // Input stall on lane 1 for three cycles, with an ignored start pulse mid-job.
        launch(vecs[5]);
        @(negedge clock);
        stall_m = 4'b0010;
        start = 1'b1;
        lane_enable = '0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_selected", 64'(m_selected), 0);
            check("stall_pop", 64'(lane_pop), 0);
            @(negedge clock);
            start = 1'b0;
        end
        stall_m = '0;
        finish_job(vecs[5], 1);

        // Output backpressure for five cycles with a beat held.
        launch(vecs[5]);
        repeat (2) @(negedge clock);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_valid", 64'(out_valid), 1);
            check("bp_coord", 64'(out_coord), 64'(exp_q[0].coord));
            check("bp_selected", 64'(m_selected), 0);
            @(negedge clock);
        end
        out_ready = 1'b1;
        finish_job(vecs[5], 1);

        // Reset in the middle of MERGE, then a fresh job.
        launch(vecs[5]);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("mid_rst_pop", 64'(lane_pop), 0);
        check("mid_rst_selected", 64'(m_selected), 0);
        @(negedge clock);
        check("post_rst_busy", 64'(busy), 0);
        check("post_rst_valid", 64'(out_valid), 0);
        check("post_rst_pop", 64'(lane_pop), 0);
        check("post_rst_coord_in", 64'(m_coord_in), 64'({R{SENTINEL}}));
        reset = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clock);
        check("post_rst_no_done", 64'(done_count), 0);
        launch(vecs[1]);
        finish_job(vecs[1], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d of %0d checks failed so far", fails, tests);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/merger_lane_scheduler.md
Name: merger_lane_scheduler

Overview:
- Sequences RADIX input coordinate fibers through one `merger` instance.
- Holds `merger.selected` until every live lane presents a valid head.
- Drives the all-ones sentinel on lanes whose fiber has ended.
- Pops lanes according to `merger.fetch_next` and registers the merged coordinate onto a valid/ready output stream.
- Sits between the per-lane fiber FIFOs and the downstream accumulator in the SpGEMM merge tree.

Parameters:
- MERGER_RADIX, 4, number of input lanes; must equal the instantiated merger's radix.
- MERGER_COORD_BITS, 8, coordinate width. Value {MERGER_COORD_BITS{1'b1}} is reserved as the exhausted-lane sentinel.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  pulse in IDLE; latches lane_enable and begins a merge job.
- lane_enable  in  RADIX  lanes participating in the job.
- lane_valid  in  RADIX  head coordinate valid, per lane.
- lane_last  in  RADIX  head is the final element of that lane's fiber.
- lane_coord  in  RADIX*COORD_BITS  head coordinates; lane i at [i*C +: C].
- lane_pop  out  RADIX  dequeue strobe, per lane.
- m_coord_in  out  RADIX*COORD_BITS  to merger.coord_in.
- m_selected  out  1  to merger.selected.
- m_fetch_next  in  RADIX  from merger.fetch_next.
- m_coord  in  COORD_BITS  from merger.coord.
- out_valid  out  1  merged coordinate valid.
- out_coord  out  COORD_BITS  merged coordinate.
- out_last  out  1  final coordinate of the job.
- out_ready  in  1  downstream accept.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse when the job completes.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE; live mask=0.
  - All outputs 0, except m_coord_in, which is all sentinel.
- Live mask:
  - start in IDLE: live <= lane_enable; go to MERGE.
  - start==1 with lane_enable==0: go directly to DONE.
  - start outside IDLE is ignored.
- m_coord_in[i]: lane_coord[i] if live[i], else sentinel.
- Merger contract: merger.coord and merger.fetch_next are combinational functions of coord_in while selected==1.
- Fire condition, in MERGE only: fire = (lane_valid | ~live) all-ones AND (out_valid==0 OR out_ready==1).
- m_selected = fire.
- Stall cases (m_selected=0):
  - any live lane not valid;
  - output stage full while out_ready==0.
- On fire:
  - lane_pop[i] = fetch_next[i] & live[i], same cycle. Multiple lanes pop together when coordinates tie.
  - out_coord <= m_coord and out_valid <= 1 at the next edge (latency 1 cycle from fire).
  - For each popped lane with lane_last[i]: live[i] <= 0.
  - If every remaining live lane is popped-and-last: out_last <= 1; state <= DRAIN.
- Output stage:
  - out_valid clears when out_ready is high and no new fire occurs in that cycle.
  - Back-to-back fire at out_ready==1 sustains one coordinate per cycle.
- DRAIN: wait for out_valid&out_ready on the out_last beat, then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Protocol violations:
  - A fetch_next bit asserted on a non-live lane is masked, never popped.
  - A live lane presenting the sentinel value is a protocol error; behaviour is undefined. A bench assertion flags it.
- reset mid-job aborts immediately:
  - no lane_pop in the reset cycle;
  - output beat discarded;
  - no done pulse.
- busy = (state != IDLE).

Optional Feature:
- Macro MERGER_SCHED_PERF_COUNTERS_EN.
- Defined:
  - Adds outputs perf_out_beats[31:0], perf_input_stalls[31:0] and perf_output_stalls[31:0].
  - All three clear on start.
  - They count, respectively: output handshakes; MERGE cycles blocked by a non-valid live lane; MERGE cycles blocked by out_valid&~out_ready.
  - All counters saturate at all-ones.
- Undefined: ports and logic are absent; the block is otherwise identical.

Decomposition:
- Shared package merger_defines: `RADIX`, `COORD_BITS`, sentinel constant, and FSM state encodings (IDLE=0, MERGE=1, DRAIN=2, DONE=3).
- One natural sub-module, merger_sched_outreg: a 1-entry valid/ready skid register carrying coord and last.
- The merger itself is instantiated alongside the scheduler by the parent, not inside it.

Test Plan:
1. Single lane: enable=4'b0001; lane 0 holds {1,5,9}, last on 9 -> out_coord 1,5,9 on consecutive cycles; out_last with 9; done one cycle after the final handshake.
2. Four lanes, heads (3,2,4,5) then (7,6,8,9) with last on the second element, out_ready=1 -> out stream 2,3,4,5,6,7,8,9; exactly one lane_pop per beat.
3. Tie: lane0 head=4, lane2 head=4 -> single out beat 4; lane_pop=4'b0101 in the same cycle.
4. Input stall: lane1 valid drops for 3 cycles mid-job -> m_selected=0 and no pops for those 3 cycles; output order unchanged.
5. Backpressure: out_ready=0 for 5 cycles with a beat held -> out_coord stable, out_valid held, m_selected=0; resumes at 1 beat/cycle.
6. Reset (reset=0) asserted mid-MERGE -> next cycle busy=0, out_valid=0, lane_pop=0, no done; a new start then runs to correct completion.
